// File: rtl/vga_mon_pkg.sv
// rtl/vga_mon_pkg.sv - shared constants, widths and state type for the VGA PMOD monitor
package vga_mon_pkg;

    localparam int PIX_R1 = 0;
    localparam int PIX_G1 = 1;
    localparam int PIX_B1 = 2;
    localparam int PIX_VS = 3;
    localparam int PIX_R0 = 4;
    localparam int PIX_G0 = 5;
    localparam int PIX_B0 = 6;
    localparam int PIX_HS = 7;

    localparam int HCNT_W = 11;
    localparam int VCNT_W = 10;
    localparam int CRC_W  = 16;

    localparam logic [HCNT_W-1:0] HCNT_MAX = '1;
    localparam logic [VCNT_W-1:0] VCNT_MAX = '1;

    localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
    localparam logic [CRC_W-1:0] CRC_SEED = 16'hFFFF;

    typedef enum logic {
        SEEK,
        MEASURE
    } state_e;

    function automatic logic [HCNT_W-1:0] sat_inc_h(input logic [HCNT_W-1:0] v);
        return (v == HCNT_MAX) ? v : v + HCNT_W'(1);
    endfunction

    function automatic logic [VCNT_W-1:0] sat_inc_v(input logic [VCNT_W-1:0] v);
        return (v == VCNT_MAX) ? v : v + VCNT_W'(1);
    endfunction

endpackage

// File: rtl/crc16_6b.sv
// rtl/crc16_6b.sv - combinational CRC-16-CCITT step over 6 data bits, MSB first
module crc16_6b
    import vga_mon_pkg::*;
(
    input  logic [CRC_W-1:0] crc_i,
    input  logic [5:0]       data_i,
    output logic [CRC_W-1:0] crc_o
);

    logic [CRC_W-1:0] acc;

    always_comb begin
        acc = crc_i;
        for (int i = 5; i >= 0; i--) begin
            if (acc[CRC_W-1] ^ data_i[i]) begin
                acc = {acc[CRC_W-2:0], 1'b0} ^ CRC_POLY;
            end else begin
                acc = {acc[CRC_W-2:0], 1'b0};
            end
        end
        crc_o = acc;
    end

endmodule

// File: rtl/vga_pmod_monitor.sv
// rtl/vga_pmod_monitor.sv - passive TinyVGA PMOD receiver: line/frame timing, per-frame CRC, lock
module vga_pmod_monitor
    import vga_mon_pkg::*;
#(
    parameter int H_TOTAL_EXP     = 800,
    parameter int HSYNC_W_EXP     = 96,
    parameter int V_TOTAL_EXP     = 525,
    parameter int VSYNC_W_EXP     = 2,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  vga_in,
    output logic        frame_valid,
    output logic [10:0] h_total,
    output logic [10:0] h_sync_w,
    output logic [9:0]  v_total,
    output logic [9:0]  v_sync_w,
    output logic        h_stable,
    output logic [15:0] crc,
    output logic        locked,
    output logic [7:0]  frame_count
);

    logic              hs_q, hs_prev_q, vs_q, vs_prev_q;
    logic [5:0]        pix_q;
    state_e            state_q;

    logic [HCNT_W-1:0] hcnt_q, hsw_cnt_q, hsw_q, ref_q, last_len_q;
    logic              line_ok_q, ref_valid_q, stable_q, match_prev_q;
    logic [VCNT_W-1:0] vcnt_q, vscnt_q;
    logic [CRC_W-1:0]  crc_q, crc_next;

    logic              frame_valid_q, h_stable_q, locked_q;
    logic [HCNT_W-1:0] h_total_q, h_sync_w_q;
    logic [VCNT_W-1:0] v_total_q, v_sync_w_q;
    logic [CRC_W-1:0]  crc_out_q;
    logic [7:0]        frame_count_q;

    logic              hs_rise, hs_fall, vs_rise, take_len, sat, match;
    logic [HCNT_W-1:0] hcnt_d, hsw_cnt_d, hsw_d, ref_d, last_len_d;
    logic              line_ok_d, ref_valid_d, stable_d;
    logic [VCNT_W-1:0] vcnt_d, vscnt_d;
    logic [CRC_W-1:0]  crc_d;

    assign hs_rise = hs_q & ~hs_prev_q;
    assign hs_fall = ~hs_q & hs_prev_q;
    assign vs_rise = vs_q & ~vs_prev_q;

    crc16_6b u_crc (
        .crc_i  (crc_q),
        .data_i (pix_q),
        .crc_o  (crc_next)
    );

    // HSYNC processing is evaluated first so that a line ending on the
    // same clock as a VSYNC edge still belongs to the frame that is closing.
    always_comb begin
        hcnt_d      = hs_rise ? HCNT_W'(1) : sat_inc_h(hcnt_q);
        line_ok_d   = line_ok_q | hs_rise;
        hsw_cnt_d   = hs_q ? (hs_rise ? HCNT_W'(1) : sat_inc_h(hsw_cnt_q)) : '0;
        hsw_d       = hs_fall ? hsw_cnt_q : hsw_q;
        vcnt_d      = hs_rise ? sat_inc_v(vcnt_q) : vcnt_q;
        vscnt_d     = (hs_rise && vs_q) ? sat_inc_v(vscnt_q) : vscnt_q;
        take_len    = hs_rise & line_ok_q;
        last_len_d  = take_len ? hcnt_q : last_len_q;
        ref_valid_d = ref_valid_q | take_len;
        ref_d       = (take_len && !ref_valid_q) ? hcnt_q : ref_q;
        stable_d    = stable_q & ~(take_len & ref_valid_q & (hcnt_q != ref_q));
        crc_d       = (!hs_q && !vs_q) ? crc_next : crc_q;

        sat   = (last_len_d == HCNT_MAX) || (hsw_d == HCNT_MAX)
             || (vcnt_d == VCNT_MAX) || (vscnt_d == VCNT_MAX);
        match = !sat && ref_valid_d && stable_d
             && (last_len_d == HCNT_W'(H_TOTAL_EXP))
             && (hsw_d == HCNT_W'(HSYNC_W_EXP))
             && (vcnt_d == VCNT_W'(V_TOTAL_EXP))
             && (vscnt_d == VCNT_W'(VSYNC_W_EXP));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Syncs reset to "asserted" so a pin already in sync cannot fake an edge.
            hs_q          <= 1'b1;
            hs_prev_q     <= 1'b1;
            vs_q          <= 1'b1;
            vs_prev_q     <= 1'b1;
            pix_q         <= '0;
            state_q       <= SEEK;
            hcnt_q        <= '0;
            hsw_cnt_q     <= '0;
            hsw_q         <= '0;
            ref_q         <= '0;
            last_len_q    <= '0;
            line_ok_q     <= 1'b0;
            ref_valid_q   <= 1'b0;
            stable_q      <= 1'b0;
            match_prev_q  <= 1'b0;
            vcnt_q        <= '0;
            vscnt_q       <= '0;
            crc_q         <= CRC_SEED;
            frame_valid_q <= 1'b0;
            h_total_q     <= '0;
            h_sync_w_q    <= '0;
            v_total_q     <= '0;
            v_sync_w_q    <= '0;
            h_stable_q    <= 1'b0;
            crc_out_q     <= '0;
            locked_q      <= 1'b0;
            frame_count_q <= '0;
        end else begin
            hs_q      <= vga_in[PIX_HS] ^ SYNC_ACTIVE_LOW;
            vs_q      <= vga_in[PIX_VS] ^ SYNC_ACTIVE_LOW;
            hs_prev_q <= hs_q;
            vs_prev_q <= vs_q;
            pix_q     <= {vga_in[PIX_R1], vga_in[PIX_R0], vga_in[PIX_G1],
                          vga_in[PIX_G0], vga_in[PIX_B1], vga_in[PIX_B0]};

            frame_valid_q <= 1'b0;

            case (state_q)
                SEEK: begin
                    if (vs_rise) begin
                        state_q   <= MEASURE;
                        hcnt_q    <= hs_rise ? HCNT_W'(1) : '0;
                        line_ok_q <= hs_rise;
                        hsw_cnt_q <= HCNT_W'(hs_rise);
                        hsw_q     <= '0;
                    end
                end
                MEASURE: begin
                    hcnt_q      <= hcnt_d;
                    line_ok_q   <= line_ok_d;
                    hsw_cnt_q   <= hsw_cnt_d;
                    hsw_q       <= hsw_d;
                    vcnt_q      <= vcnt_d;
                    vscnt_q     <= vscnt_d;
                    last_len_q  <= last_len_d;
                    ref_valid_q <= ref_valid_d;
                    ref_q       <= ref_d;
                    stable_q    <= stable_d;
                    crc_q       <= crc_d;
                    if (vs_rise) begin
                        frame_valid_q <= 1'b1;
                        h_total_q     <= last_len_d;
                        h_sync_w_q    <= hsw_d;
                        v_total_q     <= vcnt_d;
                        v_sync_w_q    <= vscnt_d;
                        h_stable_q    <= stable_d & ref_valid_d;
                        crc_out_q     <= crc_q;
                        frame_count_q <= frame_count_q + 8'd1;
                        locked_q      <= match & match_prev_q;
                        match_prev_q  <= match;
                    end
                end
                default: state_q <= SEEK;
            endcase

            // The new frame begins on the same edge that closed the last one.
            if (vs_rise) begin
                vcnt_q      <= '0;
                vscnt_q     <= '0;
                last_len_q  <= '0;
                ref_valid_q <= 1'b0;
                ref_q       <= '0;
                stable_q    <= 1'b1;
                crc_q       <= CRC_SEED;
            end
        end
    end

    assign frame_valid = frame_valid_q;
    assign h_total     = h_total_q;
    assign h_sync_w    = h_sync_w_q;
    assign v_total     = v_total_q;
    assign v_sync_w    = v_sync_w_q;
    assign h_stable    = h_stable_q;
    assign crc         = crc_out_q;
    assign locked      = locked_q;
    assign frame_count = frame_count_q;

endmodule

// File: doc/vga_pmod_monitor.md
# vga_pmod_monitor

Passive receiver for the TinyVGA PMOD pixel/sync bus driven on `uo_out` by our VGA pattern generators, such as the colour-bar test design. It recovers line and frame timing from HSYNC/VSYNC, measures totals and sync widths, computes a per-frame CRC over the 6-bit pixel data, and reports a lock flag when timing matches the expected mode. It sits in simulation and bring-up harnesses as the consumer end of the VGA output interface.

## Interface
Parameters:
- `H_TOTAL_EXP`, 800: expected clocks per line.
- `HSYNC_W_EXP`, 96: expected HSYNC pulse width in clocks.
- `V_TOTAL_EXP`, 525: expected lines per frame.
- `VSYNC_W_EXP`, 2: expected VSYNC width in lines.
- `SYNC_ACTIVE_LOW`, 1: sync polarity; 1 means a sync is asserted when its pin is 0.

Ports:
- `clk` in 1: pixel clock, the same clock as the source design.
- `rst` in 1: synchronous, active-high reset.
- `vga_in` in 8: PMOD bus. Bit assignment: [0]=R1, [1]=G1, [2]=B1, [3]=VSYNC, [4]=R0, [5]=G0, [6]=B0, [7]=HSYNC.
- `frame_valid` out 1: one-cycle strobe; all result outputs update on this cycle.
- `h_total` out 11: clocks in the last complete line of the frame.
- `h_sync_w` out 11: HSYNC asserted width, in clocks, for that line.
- `v_total` out 10: lines in the frame.
- `v_sync_w` out 10: lines during which VSYNC was asserted.
- `h_stable` out 1: every complete line in the frame had the same `h_total`.
- `crc` out 16: CRC of the frame's pixel data.
- `locked` out 1: timing matches the expected mode over consecutive frames.
- `frame_count` out 8: number of frames measured, wrapping.

## Operation
- **Input stage**
  - `vga_in` is registered once.
  - Syncs are normalised to active-high using `SYNC_ACTIVE_LOW`.
  - An edge is an asserting transition between the registered sample and the previous registered sample.
- **SEEK state (after reset)**
  - Counters and the CRC are idle; no strobes.
  - On the first VSYNC asserting edge, go to MEASURE and clear all frame accumulators.
- **MEASURE state**
  - `hcnt` increments every clock.
  - On each HSYNC asserting edge:
    - latch `hcnt` as the line length and reset `hcnt` to 1;
    - increment `vcnt`;
    - if VSYNC is asserted, increment `vscnt`.
  - The first line length in a frame is stored as the reference. Any later line that differs clears the frame's stability bit.
  - HSYNC width: count asserted clocks and latch on the HSYNC deasserting edge.
- **CRC**
  - CRC-16-CCITT: polynomial 0x1021, initial value 0xFFFF, no reflection, no final XOR.
  - Each clock where both syncs are deasserted, shift in 6 bits MSB-first: {R1,R0,G1,G0,B1,B0}.
- **End of frame** (next VSYNC asserting edge)
  - Latch all results and pulse `frame_valid`.
  - Increment `frame_count`.
  - Reinitialise accumulators for the new frame, which starts on this same edge. Stay in MEASURE.
- **Lock**
  - `match` = (`h_total`==`H_TOTAL_EXP`) && (`h_sync_w`==`HSYNC_W_EXP`) && (`v_total`==`V_TOTAL_EXP`) && (`v_sync_w`==`VSYNC_W_EXP`) && `h_stable`.
  - `locked` sets on the second consecutive frame with `match`.
  - `locked` clears on the first frame without `match`.
- **Saturation**
  - `hcnt` and the width counters saturate at 2047.
  - `vcnt` and `vscnt` saturate at 1023.
  - Any saturated count forces `match`=0.
- **Reset mid-frame:** returns to SEEK. A full frame is required before the next `frame_valid`.

## Timing
- **Reset values:** all outputs 0, including `crc`=0x0000, `locked`=0 and `frame_count`=0.
- **Strobe latency:** `frame_valid` is high exactly 2 clocks after the VSYNC pin asserting transition (1 clock input register, 1 clock result register).
- **Result hold:** results hold their values until the next `frame_valid`.
- **Simultaneous edges:** if HSYNC and VSYNC assert on the same clock, the HSYNC edge is processed first. That line is the last line counted in the ending frame; the new frame starts with `vcnt`=0.
- **Partial line:** a line cut off by the end of a frame is not included in `h_stable`.
- **Lock update:** `locked` changes only on `frame_valid` cycles.

## Structure
- **Package `vga_mon_pkg`:**
  - PMOD bit index constants;
  - CRC polynomial and seed;
  - counter widths;
  - state enum {SEEK, MEASURE}.
- **Sub-module `crc16_6b`:** combinational next-CRC function, 6 data bits per step.

## Test plan
- **Reset:** hold `rst`=1 for 5 clocks with random `vga_in` → all outputs 0 and no `frame_valid`.
- **Nominal 640×480@60 timing, 4 frames, all-black pixels** → 3 `frame_valid` strobes, each 2 clocks after a VSYNC pin edge. Each reports `h_total`=800, `h_sync_w`=96, `v_total`=525, `v_sync_w`=2, `h_stable`=1. `locked`=1 from the 2nd strobe; `frame_count` reads 1, 2, 3.
- **Line 200 stretched to 801 clocks** → that frame has `h_stable`=0 and `locked` falls to 0. Two clean frames later, `locked`=1 again.
- **Colour-bar frames from `tt_um_vga_cbtest`** → `crc` is identical across consecutive frames. Flipping one pixel's R1 gives a different `crc` that matches the reference-model value.
- **Reset asserted mid-frame (line 300)** → no strobe at the next VSYNC edge. The first strobe comes at the following VSYNC edge with nominal values.
- **HSYNC held deasserted for 3000 clocks** → `h_total`=2047 and `locked`=0.
